axi_slv_wr_ctrl: RTL and testbench

//  AXI4 slave write-path controller on the slv_if side of axi_if. Accepts one AW

---
 rtl/axi_slv_wr_ctrl_pkg.sv | 33 +++
 rtl/axi_slv_wr_ctrl_if.sv | 49 ++++
 rtl/axi_slv_wr_ctrl_addr_gen.sv | 35 +++
 rtl/axi_slv_wr_ctrl.sv | 149 ++++++++++++++
 tb/tb_axi_slv_wr_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slv_wr_ctrl_pkg.sv
// rtl/axi_slv_wr_ctrl_pkg.sv - shared AXI write-path types, widths and helpers
package axi_slv_wr_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_slv_wr_ctrl_if.sv
// rtl/axi_slv_wr_ctrl_if.sv - AXI4 write-channel bundle (AW, W, B) with modports
interface axi_slv_wr_ctrl_if
  import axi_slv_wr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = axi_slv_wr_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_slv_wr_ctrl_pkg::DATA_WIDTH,
  parameter int ID_WIDTH   = axi_slv_wr_ctrl_pkg::ID_WIDTH
) ();

  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [ID_WIDTH-1:0]     WID;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

endinterface

// File: rtl/axi_slv_wr_ctrl_addr_gen.sv
// rtl/axi_slv_wr_ctrl_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_slv_wr_ctrl_addr_gen
  import axi_slv_wr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = axi_slv_wr_ctrl_pkg::ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] total;
  logic [ADDR_WIDTH-1:0] lower;
  logic [ADDR_WIDTH-1:0] incr;

  assign bytes = ADDR_WIDTH'(1) << size_i;
  assign total = (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i;
  assign lower = addr_i & ~(total - ADDR_WIDTH'(1));
  assign incr  = addr_i + bytes;

  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr;
      // Stepping onto the upper boundary folds back to the wrap base.
      BURST_WRAP:  next_addr_o = (incr == lower + total) ? lower : incr;
      default:     next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_slv_wr_ctrl.sv
// rtl/axi_slv_wr_ctrl.sv - AXI4 slave write controller: one AW burst, its W beats, one B
module axi_slv_wr_ctrl
  import axi_slv_wr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = axi_slv_wr_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_slv_wr_ctrl_pkg::DATA_WIDTH,
  parameter int ID_WIDTH   = axi_slv_wr_ctrl_pkg::ID_WIDTH
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  axi_slv_wr_ctrl_if.slave        s_axi,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] mem_wr_strb
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int LOG2_STRB = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

  localparam logic [1:0] ST_IDLE = WR_IDLE;
  localparam logic [1:0] ST_DATA = WR_DATA;
  localparam logic [1:0] ST_RESP = WR_RESP;

  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  supp_q, supp_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs, w_hs, b_hs;
  logic                  last_beat, wlast_bad, aw_illegal;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic unused_ok;
  assign unused_ok = ^{s_axi.AWPROT, s_axi.WID};

  assign s_axi.AWREADY = (state_q == ST_IDLE) && !ARESET;
  assign s_axi.WREADY  = (state_q == ST_DATA);
  assign s_axi.BVALID  = (state_q == ST_RESP);
  assign s_axi.BID     = id_q;
  assign s_axi.BRESP   = bresp_q;

  assign aw_hs = s_axi.AWVALID && s_axi.AWREADY;
  assign w_hs  = s_axi.WVALID && s_axi.WREADY;
  assign b_hs  = s_axi.BVALID && s_axi.BREADY;

  // The beat count ends the burst; WLAST only feeds the error flag.
  assign last_beat = (cnt_q == len_q);
  assign wlast_bad = s_axi.WLAST ^ last_beat;

  assign aw_illegal = (s_axi.AWBURST == BURST_RSVD)
                   || (s_axi.AWSIZE > 3'(LOG2_STRB))
                   || ((s_axi.AWBURST == BURST_WRAP) && !wrap_len_ok(s_axi.AWLEN));

  assign mem_wr_en   = w_hs && !supp_q && !ARESET;
  assign mem_wr_addr = addr_q & ALIGN_MASK;
  assign mem_wr_data = s_axi.WDATA;
  assign mem_wr_strb = s_axi.WSTRB;

  axi_slv_wr_ctrl_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    supp_d  = supp_q;
    bresp_d = bresp_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d    = s_axi.AWID;
          addr_d  = s_axi.AWADDR;
          len_d   = s_axi.AWLEN;
          size_d  = s_axi.AWSIZE;
          burst_d = s_axi.AWBURST;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          supp_d  = aw_illegal;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          err_d  = err_q || wlast_bad;
          if (last_beat) begin
            cnt_d   = 8'd0;
            bresp_d = (err_q || wlast_bad || supp_q) ? RESP_SLVERR : RESP_OKAY;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      supp_q  <= 1'b0;
      bresp_q <= 2'b00;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      supp_q  <= supp_d;
      bresp_q <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axi_slv_wr_ctrl.sv
// tb/tb_axi_slv_wr_ctrl.sv - scoreboard bench for the AXI4 slave write controller
module tb_axi_slv_wr_ctrl;
  import axi_slv_wr_ctrl_pkg::*;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi_slv_wr_ctrl_if bus ();

  logic                    mem_wr_en;
  logic [ADDR_WIDTH-1:0]   mem_wr_addr;
  logic [DATA_WIDTH-1:0]   mem_wr_data;
  logic [DATA_WIDTH/8-1:0] mem_wr_strb;

  axi_slv_wr_ctrl dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .s_axi       (bus),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_strb (mem_wr_strb)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_exp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  wr_exp_t wr_q[$];
  b_exp_t  b_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference address: wrap computed as an offset modulo the wrap window.
  function automatic logic [31:0] exp_addr(input logic [31:0] start, input int i,
                                           input logic [2:0] size, input logic [7:0] len,
                                           input logic [1:0] burst);
    logic [31:0] bytes, total, lower, a;
    bytes = 32'd1 << size;
    a = start;
    case (burst)
      2'b01: a = start + 32'(i) * bytes;
      2'b10: begin
        total = (32'(len) + 32'd1) * bytes;
        lower = start - (start % total);
        a = lower + ((start - lower + 32'(i) * bytes) % total);
      end
      default: a = start;
    endcase
    return a & ~32'h3;
  endfunction

  always @(negedge ACLK) begin : monitor
    wr_exp_t we;
    b_exp_t  be;
    if (ARESET) begin
      chk("no_wr_in_rst", 64'(mem_wr_en), 64'd0);
    end else begin
      if (mem_wr_en) begin
        chk("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          we = wr_q.pop_front();
          chk("wr_addr", 64'(mem_wr_addr), 64'(we.addr));
          chk("wr_data", 64'(mem_wr_data), 64'(we.data));
          chk("wr_strb", 64'(mem_wr_strb), 64'(we.strb));
        end
      end
      if (bus.BVALID && bus.BREADY) begin
        chk("b_expected", 64'(b_q.size() != 0), 64'd1);
        if (b_q.size() != 0) begin
          be = b_q.pop_front();
          chk("bid", 64'(bus.BID), 64'(be.id));
          chk("bresp", 64'(bus.BRESP), 64'(be.resp));
        end
      end
    end
  end

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(posedge ACLK); #1;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
    bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
    @(negedge ACLK);
    while (!bus.AWREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("aw_wait", 64'(n < 50), 64'd1);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input int first, input int nbeats,
                        input int bad_beat, input bit writes_on);
    for (int i = first; i < first + nbeats; i++) begin
      int n = 0;
      wr_exp_t we;
      bus.WDATA  = $urandom;
      bus.WSTRB  = 4'(1 << (i % 4));
      bus.WLAST  = (i == int'(len)) ^ (i == bad_beat);
      bus.WVALID = 1'b1;
      if (writes_on) begin
        we.addr = exp_addr(addr, i, size, len, burst);
        we.data = bus.WDATA;
        we.strb = bus.WSTRB;
        wr_q.push_back(we);
      end
      @(negedge ACLK);
      while (!bus.WREADY && n < 50) begin
        @(negedge ACLK);
        n++;
      end
      chk("w_wait", 64'(n < 50), 64'd1);
      @(posedge ACLK); #1;
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
  endtask

  task automatic b_recv(input logic [3:0] id, input logic [1:0] resp, input int hold);
    int n = 0;
    b_exp_t be;
    be.id = id;
    be.resp = resp;
    b_q.push_back(be);
    bus.BREADY = 1'b0;
    @(negedge ACLK);
    while (!bus.BVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("b_wait", 64'(n < 50), 64'd1);
    for (int k = 0; k < hold; k++) begin
      chk("hold_bvalid", 64'(bus.BVALID), 64'd1);
      chk("hold_bid", 64'(bus.BID), 64'(id));
      chk("hold_bresp", 64'(bus.BRESP), 64'(resp));
      chk("hold_awready", 64'(bus.AWREADY), 64'd0);
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    chk("no_aw_at_b", 64'(bus.AWREADY), 64'd0);
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
    @(negedge ACLK);
    chk("b_dropped", 64'(bus.BVALID), 64'd0);
    chk("aw_after_b", 64'(bus.AWREADY), 64'd1);
  endtask

  task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst_t, input int bad_beat,
                       input bit writes_on, input logic [1:0] resp, input int hold);
    aw_send(id, addr, len, size, burst_t);
    w_send(addr, len, size, burst_t, 0, int'(len) + 1, bad_beat, writes_on);
    b_recv(id, resp, hold);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wready"}, 64'(bus.WREADY), 64'd0);
    chk({tag, "_bvalid"}, 64'(bus.BVALID), 64'd0);
    chk({tag, "_bresp"}, 64'(bus.BRESP), 64'd0);
    chk({tag, "_bid"}, 64'(bus.BID), 64'd0);
    chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0;
    bus.AWBURST = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk_reset_vals("rst");
    chk("rst_awready", 64'(bus.AWREADY), 64'd1);

    burst(4'h5, 32'h100, 8'd3, 3'd2, 2'b01, -1, 1'b1, 2'b00, 0);
    burst(4'h6, 32'h108, 8'd3, 3'd2, 2'b10, -1, 1'b1, 2'b00, 0);
    burst(4'h7, 32'h020, 8'd2, 3'd2, 2'b00, -1, 1'b1, 2'b00, 0);
    burst(4'h8, 32'h040, 8'd1, 3'd2, 2'b11, -1, 1'b0, 2'b10, 0);
    burst(4'h9, 32'h200, 8'd3, 3'd2, 2'b01, 1, 1'b1, 2'b10, 5);
    burst(4'hA, 32'h300, 8'd3, 3'd0, 2'b01, 3, 1'b1, 2'b10, 0);
    burst(4'hB, 32'h400, 8'd2, 3'd2, 2'b10, -1, 1'b0, 2'b10, 0);
    burst(4'hC, 32'h500, 8'd1, 3'd3, 2'b01, -1, 1'b0, 2'b10, 0);
    burst(4'hD, 32'h13C, 8'd7, 3'd2, 2'b10, -1, 1'b1, 2'b00, 0);
    burst(4'hE, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, -1, 1'b1, 2'b00, 0);

    aw_send(4'h3, 32'h600, 8'd7, 3'd2, 2'b01);
    w_send(32'h600, 8'd7, 3'd2, 2'b01, 0, 1, -1, 1'b1);
    bus.WDATA = 32'hDEAD_BEEF;
    bus.WVALID = 1'b1;
    ARESET = 1'b1;
    @(negedge ACLK);
    chk_reset_vals("mid");
    chk("mid_awready", 64'(bus.AWREADY), 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    bus.WVALID = 1'b0;
    @(negedge ACLK);
    chk_reset_vals("post");
    chk("post_awready", 64'(bus.AWREADY), 64'd1);
    burst(4'h2, 32'h700, 8'd0, 3'd2, 2'b01, -1, 1'b1, 2'b00, 0);

    repeat (3) @(negedge ACLK);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("b_q_empty", 64'(b_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
